dw_stack_flags: RTL and testbench

- Fully synchronous, single-clock LIFO stack with integrated flip-flop storage.
- Next generation of the team's basic stack. Adds almost-empty/almost-full thresholds, a live word count, a synchronous clear, a simultaneous push+pop "replace top" operation and selectable error persistence.
- Intended for small control-path stacks: return-address stacks, nested-context save, parser state.

---
 rtl/dw_stack_flags_if.sv | 26 ++
 rtl/dw_stack_flags.sv | 87 ++++++++
 tb/tb_dw_stack_flags.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dw_stack_flags_if.sv
// dw_stack_flags_if: request and status bundle of the dw_stack_flags LIFO.
interface dw_stack_flags_if #(
    parameter int width = 8,
    parameter int depth = 16
);
    localparam int cw = $clog2(depth + 1);
    logic              push_req_n;
    logic              pop_req_n;
    logic              clr_n;
    logic [width-1:0]  data_in;
    logic [width-1:0]  data_out;
    logic [cw-1:0]     word_count;
    logic              empty;
    logic              almost_empty;
    logic              almost_full;
    logic              full;
    logic              error;
    modport master (
        output push_req_n, pop_req_n, clr_n, data_in,
        input  data_out, word_count, empty, almost_empty, almost_full, full, error
    );
    modport slave (
        input  push_req_n, pop_req_n, clr_n, data_in,
        output data_out, word_count, empty, almost_empty, almost_full, full, error
    );
endinterface

// File: rtl/dw_stack_flags.sv
// dw_stack_flags: flip-flop LIFO with count, threshold flags, clear, replace-top and error.
// All outputs decode registered state only; requests never reach outputs combinationally.
module dw_stack_flags #(
    parameter int width    = 8,
    parameter int depth    = 16,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = 0,
    parameter int rst_mode = 0
) (
    input logic             clk,
    input logic             rst_n,
    dw_stack_flags_if.slave s
);
    localparam int cw = $clog2(depth + 1);
    localparam int aw = $clog2(depth);
    localparam logic [cw-1:0] max_c = cw'(depth);
    logic [cw-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [aw-1:0]    top_idx, wr_idx;
    logic             push, pop, clr, is_empty, is_full, we, illegal;
    assign push     = !s.push_req_n;
    assign pop      = !s.pop_req_n;
    assign clr      = !s.clr_n;
    assign is_empty = cnt_q == '0;
    assign is_full  = cnt_q == max_c;
    assign top_idx  = aw'(cnt_q - cw'(1));
    always_comb begin
        cnt_d   = cnt_q;
        we      = 1'b0;
        wr_idx  = top_idx;
        illegal = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            illegal = is_full;
            we      = !is_full;
            wr_idx  = aw'(cnt_q);
            cnt_d   = is_full ? cnt_q : cnt_q + cw'(1);
        end else if (pop && !push) begin
            illegal = is_empty;
            cnt_d   = is_empty ? cnt_q : cnt_q - cw'(1);
        end else if (push && pop) begin
            // replace top: count unchanged, so legal even when full
            illegal = is_empty;
            we      = !is_empty;
        end
        err_d = clr ? 1'b0 : (err_mode != 0) ? illegal : (err_q | illegal);
    end
    always_comb begin
        for (int i = 0; i < depth; i++)
            mem_d[i] = (we && wr_idx == aw'(i)) ? s.data_in : mem_q[i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    generate
        if (rst_mode == 0) begin : g_mem_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < depth; i++) mem_q[i] <= '0;
                end else begin
                    mem_q <= mem_d;
                end
            end
        end else begin : g_mem_nrst
            always_ff @(posedge clk) begin
                if (rst_n) mem_q <= mem_d;
            end
        end
    endgenerate
    assign s.data_out     = is_empty ? '0 : mem_q[top_idx];
    assign s.word_count   = cnt_q;
    assign s.empty        = is_empty;
    assign s.full         = is_full;
    assign s.almost_empty = cnt_q <= cw'(ae_level);
    assign s.almost_full  = cnt_q >= cw'(depth - af_level);
    assign s.error        = err_q;
endmodule

// File: tb/tb_dw_stack_flags.sv
// tb_dw_stack_flags: directed and randomized checks of three dw_stack_flags configurations
// against an array-plus-count stack model.
module tb_dw_stack_flags;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    dw_stack_flags_if #(.width(8), .depth(16)) if0 ();
    dw_stack_flags_if #(.width(8), .depth(16)) if1 ();
    dw_stack_flags_if #(.width(8), .depth(8))  if2 ();
    dw_stack_flags #(.width(8), .depth(16), .ae_level(1), .af_level(1), .err_mode(0), .rst_mode(0))
        u0 (.clk(clk), .rst_n(rst_n), .s(if0));
    dw_stack_flags #(.width(8), .depth(16), .ae_level(1), .af_level(1), .err_mode(1), .rst_mode(1))
        u1 (.clk(clk), .rst_n(rst_n), .s(if1));
    dw_stack_flags #(.width(8), .depth(8), .ae_level(3), .af_level(2), .err_mode(0), .rst_mode(0))
        u2 (.clk(clk), .rst_n(rst_n), .s(if2));
    logic       pn [3], on [3], cn [3];
    logic [7:0] din [3];
    logic [7:0] dout [3];
    logic [8:0] wc [3];
    logic       emp [3], aem [3], afu [3], ful [3], err [3];
    assign if0.push_req_n = pn[0]; assign if0.pop_req_n = on[0]; assign if0.clr_n = cn[0]; assign if0.data_in = din[0];
    assign if1.push_req_n = pn[1]; assign if1.pop_req_n = on[1]; assign if1.clr_n = cn[1]; assign if1.data_in = din[1];
    assign if2.push_req_n = pn[2]; assign if2.pop_req_n = on[2]; assign if2.clr_n = cn[2]; assign if2.data_in = din[2];
    assign dout[0] = if0.data_out; assign wc[0] = 9'(if0.word_count); assign emp[0] = if0.empty;
    assign aem[0] = if0.almost_empty; assign afu[0] = if0.almost_full; assign ful[0] = if0.full; assign err[0] = if0.error;
    assign dout[1] = if1.data_out; assign wc[1] = 9'(if1.word_count); assign emp[1] = if1.empty;
    assign aem[1] = if1.almost_empty; assign afu[1] = if1.almost_full; assign ful[1] = if1.full; assign err[1] = if1.error;
    assign dout[2] = if2.data_out; assign wc[2] = 9'(if2.word_count); assign emp[2] = if2.empty;
    assign aem[2] = if2.almost_empty; assign afu[2] = if2.almost_full; assign ful[2] = if2.full; assign err[2] = if2.error;
    int dep [3]  = '{16, 16, 8};
    int ae_l [3] = '{1, 1, 3};
    int af_l [3] = '{1, 1, 2};
    int em [3]   = '{0, 1, 0};
    logic [7:0] mm [3][256];
    int  mc [3];
    bit  me [3];
    int  checks = 0;
    int  failures = 0;
    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            pn[k] = 1'b1; on[k] = 1'b1; cn[k] = 1'b1; din[k] = 8'h00;
        end
    endtask
    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mc[k] = 0; me[k] = 1'b0;
        end
    endtask
    // one clock: stack rules applied to the model at the edge, outputs settle by the falling edge
    task automatic cycle();
        bit ill;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            ill = 1'b0;
            if (!cn[k]) begin
                mc[k] = 0; me[k] = 1'b0;
            end else begin
                if (!pn[k] && on[k]) begin
                    if (mc[k] == dep[k]) ill = 1'b1;
                    else begin mm[k][mc[k]] = din[k]; mc[k]++; end
                end else if (pn[k] && !on[k]) begin
                    if (mc[k] == 0) ill = 1'b1;
                    else mc[k]--;
                end else if (!pn[k] && !on[k]) begin
                    if (mc[k] == 0) ill = 1'b1;
                    else mm[k][mc[k]-1] = din[k];
                end
                me[k] = (em[k] != 0) ? ill : (me[k] | ill);
            end
        end
        @(negedge clk);
        idle();
    endtask
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({emp[k], aem[k], afu[k], ful[k], err[k]} !== 5'b11000) begin
                failures++; $display("FAIL reset_flags[%0d] got=%b exp=11000", k, {emp[k], aem[k], afu[k], ful[k], err[k]});
            end
            checks++;
            if (wc[k] !== 9'd0 || dout[k] !== 8'h00) begin
                failures++; $display("FAIL reset_count_data[%0d] got wc=%0d do=%h exp 0/00", k, wc[k], dout[k]);
            end
        end
    endtask
    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            pn[0] = 1'b0; din[0] = 8'(i); cycle();
            checks++;
            if (wc[0] !== 9'(i) || dout[0] !== 8'(i)) begin
                failures++; $display("FAIL fill_step%0d got wc=%0d do=%h exp %0d/%h", i, wc[0], dout[0], i, 8'(i));
            end
            checks++;
            if (emp[0] !== 1'b0 || aem[0] !== (i <= 1) || afu[0] !== (i >= 15) || ful[0] !== (i == 16)) begin
                failures++; $display("FAIL fill_flags%0d got e=%b ae=%b af=%b f=%b", i, emp[0], aem[0], afu[0], ful[0]);
            end
        end
    endtask
    task automatic test_drain();
        for (int j = 1; j <= 16; j++) begin
            on[0] = 1'b0; cycle();
            checks++;
            if (dout[0] !== 8'(16 - j) || wc[0] !== 9'(16 - j)) begin
                failures++; $display("FAIL drain_step%0d got do=%h wc=%0d exp %h/%0d", j, dout[0], wc[0], 8'(16 - j), 16 - j);
            end
        end
        checks++;
        if (emp[0] !== 1'b1 || err[0] !== 1'b0) begin
            failures++; $display("FAIL drain_end got empty=%b error=%b exp 1/0", emp[0], err[0]);
        end
    endtask
    task automatic test_overflow_underflow();
        for (int i = 1; i <= 16; i++) begin
            pn[0] = 1'b0; din[0] = 8'(i); cycle();
        end
        pn[0] = 1'b0; din[0] = 8'hAA; cycle();
        checks++;
        if (wc[0] !== 9'd16 || dout[0] !== 8'h10 || err[0] !== 1'b1) begin
            failures++; $display("FAIL overflow got wc=%0d do=%h err=%b exp 16/10/1", wc[0], dout[0], err[0]);
        end
        cycle();
        checks++;
        if (err[0] !== 1'b1) begin
            failures++; $display("FAIL overflow_sticky got=%b exp=1", err[0]);
        end
        cn[0] = 1'b0; cycle();
        checks++;
        if (wc[0] !== 9'd0 || err[0] !== 1'b0 || emp[0] !== 1'b1 || dout[0] !== 8'h00) begin
            failures++; $display("FAIL clear got wc=%0d err=%b empty=%b do=%h exp 0/0/1/00", wc[0], err[0], emp[0], dout[0]);
        end
        on[0] = 1'b0; cycle();
        checks++;
        if (err[0] !== 1'b1 || wc[0] !== 9'd0) begin
            failures++; $display("FAIL underflow got err=%b wc=%0d exp 1/0", err[0], wc[0]);
        end
        cycle();
        checks++;
        if (err[0] !== 1'b1) begin
            failures++; $display("FAIL underflow_sticky got=%b exp=1", err[0]);
        end
        cn[0] = 1'b0; cycle();
    endtask
    task automatic test_replace_dynamic_error();
        pn[1] = 1'b0; din[1] = 8'h11; cycle();
        pn[1] = 1'b0; din[1] = 8'h22; cycle();
        pn[1] = 1'b0; on[1] = 1'b0; din[1] = 8'h33; cycle();
        checks++;
        if (wc[1] !== 9'd2 || dout[1] !== 8'h33 || err[1] !== 1'b0) begin
            failures++; $display("FAIL replace_top got wc=%0d do=%h err=%b exp 2/33/0", wc[1], dout[1], err[1]);
        end
        on[1] = 1'b0; cycle();
        checks++;
        if (dout[1] !== 8'h11 || wc[1] !== 9'd1) begin
            failures++; $display("FAIL replace_pop got do=%h wc=%0d exp 11/1", dout[1], wc[1]);
        end
        on[1] = 1'b0; cycle();
        pn[1] = 1'b0; on[1] = 1'b0; din[1] = 8'h44; cycle();
        checks++;
        if (err[1] !== 1'b1 || wc[1] !== 9'd0 || dout[1] !== 8'h00) begin
            failures++; $display("FAIL replace_empty got err=%b wc=%0d do=%h exp 1/0/00", err[1], wc[1], dout[1]);
        end
        cycle();
        checks++;
        if (err[1] !== 1'b0) begin
            failures++; $display("FAIL error_pulse_width got=%b exp=0", err[1]);
        end
    endtask
    task automatic test_async_reset();
        pn[1] = 1'b0; din[1] = 8'h5A; cycle();
        pn[1] = 1'b0; din[1] = 8'h5B; cycle();
        checks++;
        if (wc[1] !== 9'd2 || dout[1] !== 8'h5B) begin
            failures++; $display("FAIL pre_reset got wc=%0d do=%h exp 2/5b", wc[1], dout[1]);
        end
        pn[1] = 1'b0; din[1] = 8'hEE;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wc[1] !== 9'd0 || dout[1] !== 8'h00 || {emp[1], aem[1], afu[1], ful[1], err[1]} !== 5'b11000) begin
            failures++; $display("FAIL async_reset got wc=%0d do=%h flags=%b exp 0/00/11000", wc[1], dout[1], {emp[1], aem[1], afu[1], ful[1], err[1]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle();
        checks++;
        if (wc[1] !== 9'd0 || dout[1] !== 8'h00) begin
            failures++; $display("FAIL reset_aborts_push got wc=%0d do=%h exp 0/00", wc[1], dout[1]);
        end
        pn[1] = 1'b0; din[1] = 8'h77; cycle();
        checks++;
        if (wc[1] !== 9'd1 || dout[1] !== 8'h77) begin
            failures++; $display("FAIL post_reset_push got wc=%0d do=%h exp 1/77", wc[1], dout[1]);
        end
    endtask
    task automatic test_thresholds();
        for (int i = 1; i <= 8; i++) begin
            pn[2] = 1'b0; din[2] = 8'(8'hC0 + i); cycle();
            checks++;
            if (aem[2] !== (i <= 3) || afu[2] !== (i >= 6) || ful[2] !== (i == 8) || wc[2] !== 9'(i)) begin
                failures++; $display("FAIL thr_up%0d got ae=%b af=%b f=%b wc=%0d", i, aem[2], afu[2], ful[2], wc[2]);
            end
        end
        for (int i = 7; i >= 0; i--) begin
            on[2] = 1'b0; cycle();
            checks++;
            if (aem[2] !== (i <= 3) || afu[2] !== (i >= 6) || emp[2] !== (i == 0) || wc[2] !== 9'(i)) begin
                failures++; $display("FAIL thr_down%0d got ae=%b af=%b e=%b wc=%0d", i, aem[2], afu[2], emp[2], wc[2]);
            end
        end
    endtask
    task automatic test_random();
        int bias;
        for (int n = 0; n < 600; n++) begin
            bias = ((n / 60) % 2 == 0) ? 75 : 25;
            for (int k = 0; k < 3; k++) begin
                cn[k]  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
                pn[k]  = ($urandom_range(0, 99) < bias) ? 1'b0 : 1'b1;
                on[k]  = ($urandom_range(0, 99) < 100 - bias) ? 1'b0 : 1'b1;
                din[k] = 8'($urandom);
            end
            cycle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (wc[k] !== 9'(mc[k]) || dout[k] !== ((mc[k] == 0) ? 8'h00 : mm[k][mc[k]-1])) begin
                    failures++; $display("FAIL rand[%0d] n=%0d got wc=%0d do=%h exp wc=%0d", k, n, wc[k], dout[k], mc[k]);
                end
                checks++;
                if (emp[k] !== (mc[k] == 0) || ful[k] !== (mc[k] == dep[k]) || aem[k] !== (mc[k] <= ae_l[k])
                    || afu[k] !== (mc[k] >= dep[k] - af_l[k]) || err[k] !== me[k]) begin
                    failures++; $display("FAIL rand_flags[%0d] n=%0d got e=%b f=%b ae=%b af=%b err=%b exp err=%b cnt=%0d",
                        k, n, emp[k], ful[k], aem[k], afu[k], err[k], me[k], mc[k]);
                end
            end
        end
    endtask
    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_fill();
        test_drain();
        test_overflow_underflow();
        test_replace_dynamic_error();
        test_async_reset();
        test_thresholds();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
